// File: rtl/rv_isa_pkg.sv
// RV32I decode constants shared by the issue stage and its immediate generator.
package rv_isa_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SR   = 3'b101;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // Contents of the ID/EX slot, exactly what the ALU side sees.
    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            sub;
        logic [2:0]      func3;
        logic [4:0]      rd;
        logic            we;
        logic            branch;
        logic [2:0]      br_func3;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } issue_slot_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the RV32I I/S/B/U/J formats, sign-extended to 32 bits.
module imm_gen
    import rv_isa_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    // Pure bit shuffling per instruction format.
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage feeding the RV32I ALU: decodes sub/func3, selects
// operands and holds them in one registered ID/EX slot with valid/ready.
// Optional macro ALU_ISSUE_FWD_EN adds a writeback forwarding port.
module alu_issue_stage
    import rv_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rs1,
    output logic [31:0] out_rs2,
    output logic        out_sub,
    output logic [2:0]  out_func3,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_branch,
    output logic [2:0]  out_br_func3,
    output logic        out_illegal,
    output logic [31:0] out_pc
`ifdef ALU_ISSUE_FWD_EN
    ,
    input  logic        fwd_we,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data
`endif
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    imm_type_e   imm_type;
    issue_slot_t dec;
    issue_slot_t slot;
    logic        valid;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign rd     = in_instr[11:7];

`ifdef ALU_ISSUE_FWD_EN
    // A result being written back this cycle wins over stale register-file data.
    // rs2_data only reaches the slot on register-operand opcodes, so the
    // rs2 bypass cannot leak into immediate forms.
    assign rs1_data = (fwd_we && fwd_rd != 5'd0 && fwd_rd == in_instr[19:15]) ? fwd_data : in_rs1_data;
    assign rs2_data = (fwd_we && fwd_rd != 5'd0 && fwd_rd == in_instr[24:20]) ? fwd_data : in_rs2_data;
`else
    assign rs1_data = in_rs1_data;
    assign rs2_data = in_rs2_data;
`endif

    assign imm_type = (opcode == OPC_LUI || opcode == OPC_AUIPC) ? IMM_U : IMM_I;

    imm_gen u_imm_gen (
        .instr    (in_instr),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // Opcode decode into the next slot image.
    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.rd    = rd;
        dec.we    = (rd != 5'd0);
        case (opcode)
            OPC_OP: begin
                dec.rs1   = rs1_data;
                dec.rs2   = rs2_data;
                dec.func3 = funct3;
                if (funct3 == F3_ADD || funct3 == F3_SR)
                    dec.sub = in_instr[30];
                else
                    dec.sub = (funct3 == F3_SLT || funct3 == F3_SLTU);
            end
            OPC_OPIMM: begin
                dec.rs1   = rs1_data;
                dec.rs2   = imm;
                dec.func3 = funct3;
                // ADDI has no subtract form; bit 30 is immediate data there.
                if (funct3 == F3_SR)
                    dec.sub = in_instr[30];
                else
                    dec.sub = (funct3 == F3_SLT || funct3 == F3_SLTU);
            end
            OPC_BRANCH: begin
                dec.rs1      = rs1_data;
                dec.rs2      = rs2_data;
                dec.func3    = F3_ADD;
                dec.sub      = 1'b1;
                dec.branch   = 1'b1;
                dec.br_func3 = funct3;
                dec.we       = 1'b0;
            end
            OPC_LUI: begin
                dec.rs1 = '0;
                dec.rs2 = imm;
            end
            OPC_AUIPC: begin
                dec.rs1 = in_pc;
                dec.rs2 = imm;
            end
            default: begin
                dec.illegal = 1'b1;
                dec.we      = 1'b0;
            end
        endcase
    end

    assign in_ready = !valid || out_ready;

    // ID/EX slot: flush beats capture; data only moves on an accepted capture,
    // so a stalled slot holds every output stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            slot  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid <= 1'b1;
            slot  <= dec;
        end else if (out_ready) begin
            valid <= 1'b0;
        end
    end

    assign out_valid    = valid;
    assign out_rs1      = slot.rs1;
    assign out_rs2      = slot.rs2;
    assign out_sub      = slot.sub;
    assign out_func3    = slot.func3;
    assign out_rd       = slot.rd;
    assign out_we       = slot.we;
    assign out_branch   = slot.branch;
    assign out_br_func3 = slot.br_func3;
    assign out_illegal  = slot.illegal;
    assign out_pc       = slot.pc;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage directly upstream of the RV32I ALU. Accepts one instruction plus register-file read data per handshake and decodes the ALU controls (`sub`, `func3`). Selects operands (register, immediate, PC or zero) and holds everything in a registered ID/EX pipeline slot with valid/ready flow control and flush. Outputs connect straight to the ALU operand and control inputs.

## Interface
Parameters:
- none; XLEN fixed at 32.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream holds a valid instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: raw instruction word.
- `in_pc` in 32: instruction address.
- `in_rs1_data` / `in_rs2_data` in 32 each: register-file read data.
- `flush` in 1: discard slot contents and any same-cycle input.
- `out_valid` out 1: slot holds an issued op.
- `out_ready` in 1: downstream consumes this cycle.
- `out_rs1` / `out_rs2` out 32 each: ALU operands.
- `out_sub` out 1: ALU `sub` control.
- `out_func3` out 3: ALU `func3` control.
- `out_rd` out 5: destination register.
- `out_we` out 1: writeback enable.
- `out_branch` out 1: op is a conditional branch.
- `out_br_func3` out 3: branch condition, the raw funct3.
- `out_illegal` out 1: unsupported opcode.
- `out_pc` out 32: registered PC.
- `fwd_we` in 1, `fwd_rd` in 5, `fwd_data` in 32: present only with `ALU_ISSUE_FWD_EN`.

## Operation
- Decoding by opcode `in_instr[6:0]`:
  - OP 0110011:
    - rs2 operand = register.
    - `func3` = funct3.
    - `sub` = `instr[30]` for funct3 000/101.
    - `sub` = 1 for funct3 010/011.
    - `sub` = 0 otherwise.
  - OP-IMM 0010011:
    - rs2 operand = sign-extended I-immediate.
    - `sub` = 1 for 010/011.
    - `sub` = `instr[30]` for 101.
    - `sub` = 0 otherwise.
  - BRANCH 1100011:
    - Both operands are registers.
    - `func3` = 000, `sub` = 1, `out_branch` = 1, `out_we` = 0.
  - LUI 0110111: rs1 operand = 0, rs2 operand = U-immediate, `func3` = 000, `sub` = 0.
  - AUIPC 0010111: rs1 operand = `in_pc`, rs2 operand = U-immediate, `func3` = 000, `sub` = 0.
  - Any other opcode: `out_illegal` = 1, `out_we` = 0, operands 0.
- Writeback: `out_we` = 0 whenever rd == 0.
- Handshake:
  - `in_ready` = `!out_valid || out_ready`, combinational.
  - Capture into the slot when `in_valid && in_ready && !flush`.
  - `out_valid` clears after `out_ready` is seen with no new capture.
  - While stalled (`out_valid && !out_ready`), all outputs hold stable.
- `flush` has priority over capture. The next cycle shows `out_valid` = 0. A same-cycle input counts as accepted and is dropped.
- Reset: `out_valid` = 0 and all other outputs = 0. Reset mid-stall discards the slot.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 op/cycle when `out_ready` is held at 1.
- All outputs are registered. `in_ready` is the only combinational output.

## Configuration
- `ALU_ISSUE_FWD_EN` defined:
  - `fwd_*` ports exist.
  - At capture, `fwd_data` replaces `in_rs1_data` when `fwd_we && fwd_rd != 0 && fwd_rd == instr[19:15]`.
  - The same replacement applies to `in_rs2_data` (match on `instr[24:20]`), only where rs2 is used as a register operand.
- Undefined: no `fwd_*` ports; register data is used as-is.

## Structure
- Shared package `rv_isa_pkg`: opcode constants, funct3 constants, immediate-type enum.
- One sub-module, `imm_gen`: combinational I/S/B/U/J immediate extraction with sign extension.

## Test plan
- SUB x3,x1,x2 (`0x402081B3`), rs1 = 10, rs2 = 3 -> next cycle:
  - `out_valid` = 1, `out_rs1` = 10, `out_rs2` = 3.
  - `out_sub` = 1, `out_func3` = 000, `out_rd` = 3, `out_we` = 1.
- ADDI x5,x0,-1 (`0xFFF00293`) -> `out_rs2` = `0xFFFFFFFF`, `out_sub` = 0, `out_func3` = 000.
- SRAI x1,x1,4 (`0x4040D093`) -> `out_rs2` = `0x00000404`, `out_sub` = 1, `out_func3` = 101.
- Backpressure: `out_ready` = 0 for 3 cycles with the slot full -> `in_ready` = 0 and outputs unchanged. Then `out_ready` = 1 -> next op accepted.
- `flush` = 1 together with `in_valid` = 1 -> `out_valid` = 0 next cycle; then `rst` = 1 -> all outputs 0.
- `ALU_ISSUE_FWD_EN` defined, SUB above with `fwd_we` = 1, `fwd_rd` = 1, `fwd_data` = `0x55`:
  - `out_rs1` = `0x55`.
  - Repeat with `fwd_rd` = 0 -> `out_rs1` = 10.
